// File: rtl/mem_arbiter.sv
// Arbitrates the coherence bus data port and two instruction-fetch ports onto one RAM port.
// Optional fetch anti-starvation counter is enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                bus_dREN,
  input  logic                bus_dWEN,
  input  logic [ADDR_W-1:0]   bus_daddr,
  input  logic [DATA_W-1:0]   bus_dstore,
  output logic [DATA_W-1:0]   bus_dload,
  output logic                bus_dwait,
  input  logic [1:0]          iREN,
  input  logic [2*ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0]   iload,
  output logic [1:0]          iwait,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [ADDR_W-1:0]   ramaddr,
  output logic [DATA_W-1:0]   ramstore,
  input  logic [DATA_W-1:0]   ramload,
  input  logic [1:0]          ramstate,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, INST = 2'd2} state_e;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_LIMIT);

`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR_EN = 1'b1;
`else
  localparam bit FAIR_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              core_q, core_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic [DATA_W-1:0] dload_q, dload_d;
  logic [DATA_W-1:0] iload_q, iload_d;
  logic [2:0]        starve_q, starve_d;

  logic pick_k;
  logic fetch_first;

  assign state_o  = state_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  // With both cores asking, the core that was not served last wins.
  assign pick_k      = (&iREN) ? ~rr_ptr_q : iREN[1];
  assign fetch_first = FAIR_EN && (starve_q >= STARVE_LIM) && (|iREN);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    core_d    = core_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    store_d   = store_q;
    dload_d   = dload_q;
    iload_d   = iload_q;
    starve_d  = starve_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    bus_dwait = 1'b1;
    iwait     = 2'b11;
    bus_dload = dload_q;
    iload     = iload_q;

    case (state_q)
      IDLE: begin
        if ((bus_dREN || bus_dWEN) && !fetch_first) begin
          state_d = DATA;
          addr_d  = bus_daddr;
          store_d = bus_dstore;
          wr_d    = bus_dWEN;
          rd_d    = bus_dREN & ~bus_dWEN;
        end else if (|iREN) begin
          state_d  = INST;
          core_d   = pick_k;
          addr_d   = pick_k ? iaddr[ADDR_W +: ADDR_W] : iaddr[0 +: ADDR_W];
          starve_d = 3'd0;
        end
      end
      DATA: begin
        ramWEN = wr_q;
        ramREN = rd_q;
        if (!bus_dREN && !bus_dWEN) begin
          state_d = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          bus_dwait = 1'b0;
          bus_dload = ramload;
          dload_d   = ramload;
          state_d   = IDLE;
          if (FAIR_EN && (|iREN) && (starve_q != 3'd7)) starve_d = starve_q + 3'd1;
        end
      end
      INST: begin
        ramREN = 1'b1;
        if (!iREN[core_q]) begin
          state_d = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          iwait[core_q] = 1'b0;
          iload         = ramload;
          iload_d       = ramload;
          rr_ptr_d      = core_q;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      core_q   <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      dload_q  <= '0;
      iload_q  <= '0;
      starve_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      core_q   <= core_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      dload_q  <= dload_d;
      iload_q  <= iload_d;
      starve_q <= starve_d;
    end
  end

endmodule
